cmpt_inst_encdr: RTL and testbench
==================================

# cmpt_inst_encdr

Compute instruction encoder and issuer; the producing end of the compute decoder's instruction interface. It accepts field-level compute requests from the program sequencer and packs them into the 21-bit compute word plus float bit. It buffers them in a small FIFO and issues at most one per cycle with `cpt_en`. It inserts a one-cycle bubble whenever an instruction reads a register written by the instruction issued in the immediately preceding cycle, because the decoder's register-file write enable lands one cycle late.

## Interface
- `DEPTH`, 4: request FIFO entries (power of two, ≥2)
- `CNTW`, 16: stall counter width

- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-low reset
- `req_vld` in 1: request valid
- `req_rdy` out 1: FIFO not full
- `req_unit` in 2: 00 ALU, 01 MUL, 10 SHF, 11 illegal
- `req_float` in 1: floating-point flag → `bt_26`
- `req_ctl` in 7: control field, mapped verbatim to word bits [18:12]
- `req_wa` in 4: write address → [11:8]
- `req_ra0` in 4: input-1 read address → [7:4]
- `req_ray` in 4: input-2 read address → [3:0]
- `req_msc` in 2: MUL sub-classification
- `iss_hold` in 1: sequencer freeze; no issue while high
- `cpt_en` out 1: registered issue strobe
- `bt_26` out 1: registered float bit
- `bt_5t25` out 21: registered compute word
- `enc_err` out 1: one-cycle pulse; illegal unit dropped
- `stall_cnt` out CNTW: saturating count of hazard bubbles

## Operation
- Accept on `req_vld & req_rdy`. `req_rdy = (count != DEPTH)`. A full FIFO deasserts `req_rdy` even if a pop occurs in the same cycle.
- Encoding at accept time:
  - [20:19] = unit.
  - ALU: [18:12] = `req_ctl`, [11:0] = {wa, ra0, ray}.
  - MUL: [18:12] = `req_ctl`. If cls = ctl[6:5] ≠ 0, [3:0] = ray and `req_msc` is ignored. If cls = 0, [3:2] = 0 and [1:0] = msc.
  - SHF: [16:15] = ctl[4:3]; [18:17] and [14:12] are forced 0.
- Unit 11: the request is consumed but not stored. `enc_err` pulses in the cycle after the accept edge.
- Per entry, the following flags are stored alongside the word:
  - Write flag: ALU & !(!b18 & b12 & b14); MUL & !b16; SHF always.
  - Rx-used: ALU; SHF; MUL & (cls≠0 | (b16 & b[1:0]≠11)).
  - Ry-used: ALU & !b16; MUL & cls≠0; SHF & !b16.
- Hazard: the head entry conflicts if `last_wv` is set and (Rx-used & ra0 == `last_wa`, or Ry-used & ray == `last_wa`).
  - `last_wv`/`last_wa` capture the write flag and write address of the word loaded on the previous edge.
  - They clear on any edge that issues nothing.
- Issue on an edge when the head is valid, `!iss_hold`, and there is no conflict: pop, load `bt_5t25`/`bt_26`, set `cpt_en` = 1.
- Otherwise `cpt_en` = 0 and `bt_5t25`/`bt_26` hold their values.
- `stall_cnt` increments (saturating at all-ones) only on edges where the head is valid, `!iss_hold`, and a conflict blocks issue.

## Timing
- Reset values: `cpt_en` 0, `bt_26` 0, `bt_5t25` 0, `enc_err` 0, `stall_cnt` 0, `req_rdy` 1. Reset also empties the FIFO and clears `last_wv`.
- Reset mid-operation discards all queued entries; no partial issue occurs.
- Latency: a request accepted at edge E into an empty FIFO drives `cpt_en` high after edge E+1. There is no bypass path.
- Throughput: one instruction per cycle absent hazards. A hazard costs exactly one bubble, because the bubble clears `last_wv`.
- `iss_hold` is sampled at the edge. Hold asserted at edge E means no issue at E, and a hazard then clears.
- Push and pop in the same edge leave the count unchanged. Pointers wrap modulo `DEPTH`.

## Structure
- Package `cmpt_pkg`:
  - Unit codes.
  - Word bit positions: UNIT [20:19], HC/CLS [18:17], WA [11:8], RX [7:4], RY [3:0].
  - Entry struct: word, float, wflag, rxu, ryu.
- Sub-module `cmpt_iss_fifo`: parameterised synchronous FIFO, with count and full/empty flags.
- Encoder, hazard check and output registers live in the top.

## Test plan
- ALU, ctl=7'b0000000, wa=3, ra0=1, ray=2 → after 2 edges `cpt_en`=1, `bt_5t25`=21'h000312.
- Back-to-back ALU writing R5, then ALU reading ra0=5 → second issue delayed one cycle, `stall_cnt`=1. The same pair with reads of R6 shows no bubble.
- MUL cls=0, otreg=1, msc=2'b11, ray=4'hF → word [3:0]=4'b0011. The instruction is Rx-unused, so no stall even though ra0 matches the prior write.
- 5 requests with `iss_hold`=1 → `req_rdy` drops after 4. Releasing the hold issues 4 words in order, then the 5th after re-accept.
- unit=2'b11 → `enc_err` pulses once, no `cpt_en`, FIFO count unchanged.
- `rst` low with 3 entries queued → all outputs 0; no issue after release until a new accept.

Source files
------------

// File: rtl/cmpt_pkg.sv
// Shared types and word layout for the compute instruction encoder/issuer.
package cmpt_pkg;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'b00,
    UNIT_MUL = 2'b01,
    UNIT_SHF = 2'b10,
    UNIT_ILL = 2'b11
  } unit_e;

  localparam int WORD_W  = 21;
  localparam int UNIT_HI = 20;
  localparam int UNIT_LO = 19;
  localparam int HC_HI   = 18;
  localparam int HC_LO   = 17;
  localparam int CTL_HI  = 18;
  localparam int CTL_LO  = 12;
  localparam int WA_HI   = 11;
  localparam int WA_LO   = 8;
  localparam int RX_HI   = 7;
  localparam int RX_LO   = 4;
  localparam int RY_HI   = 3;
  localparam int RY_LO   = 0;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              flt;
    logic              wflag;
    logic              rxu;
    logic              ryu;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/cmpt_iss_fifo.sv
// Synchronous request FIFO with occupancy count; power-of-two depth so pointers wrap naturally.
module cmpt_iss_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PONE = 1;
  localparam logic [CW-1:0] CONE = 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CONE;
      2'b01:   count_d = count_q - CONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PONE;
      if (do_pop)  rptr_q <= rptr_q + PONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cmpt_inst_encdr.sv
// Packs field-level compute requests into the 21-bit compute word, queues them,
// and issues one per cycle, inserting a bubble on read-after-write to the previous issue.
module cmpt_inst_encdr
  import cmpt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [1:0]        req_unit,
  input  logic              req_float,
  input  logic [6:0]        req_ctl,
  input  logic [3:0]        req_wa,
  input  logic [3:0]        req_ra0,
  input  logic [3:0]        req_ray,
  input  logic [1:0]        req_msc,
  input  logic              iss_hold,
  output logic              cpt_en,
  output logic              bt_26,
  output logic [WORD_W-1:0] bt_5t25,
  output logic              enc_err,
  output logic [CNTW-1:0]   stall_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] SONE = 1;

  unit_e             unit;
  logic [1:0]        cls;
  entry_t            new_ent, head;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic              accept, push, ill_acc;
  logic              conflict, can_go, issue, stall;

  logic              cpt_en_q, bt_26_q, enc_err_q, last_wv_q;
  logic [WORD_W-1:0] bt_5t25_q;
  logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [3:0]        last_wa_q;

  assign unit    = unit_e'(req_unit);
  assign cls     = req_ctl[6:5];
  assign req_rdy = (fifo_cnt != CW'(DEPTH));
  assign accept  = req_vld & ~fifo_full;
  assign push    = accept & (unit != UNIT_ILL);
  assign ill_acc = accept & (unit == UNIT_ILL);

  always_comb begin
    new_ent = '0;
    new_ent.flt = req_float;
    new_ent.word[UNIT_HI:UNIT_LO] = req_unit;
    new_ent.word[WA_HI:WA_LO]     = req_wa;
    new_ent.word[RX_HI:RX_LO]     = req_ra0;
    new_ent.word[RY_HI:RY_LO]     = req_ray;
    unique case (unit)
      UNIT_ALU: new_ent.word[CTL_HI:CTL_LO] = req_ctl;
      UNIT_MUL: begin
        new_ent.word[CTL_HI:CTL_LO] = req_ctl;
        // Class 0 multiplies carry the sub-classification in place of Ry
        if (cls == 2'b00) new_ent.word[RY_HI:RY_LO] = {2'b00, req_msc};
      end
      UNIT_SHF: begin
        new_ent.word[HC_HI:HC_LO] = 2'b00;
        new_ent.word[16:15]       = req_ctl[4:3];
        new_ent.word[14:12]       = 3'b000;
      end
      default: ;
    endcase

    // Register-usage flags are derived from the packed word, as the decoder sees it
    unique case (unit)
      UNIT_ALU: begin
        new_ent.wflag = ~(~new_ent.word[18] & new_ent.word[12] & new_ent.word[14]);
        new_ent.rxu   = 1'b1;
        new_ent.ryu   = ~new_ent.word[16];
      end
      UNIT_MUL: begin
        new_ent.wflag = ~new_ent.word[16];
        new_ent.rxu   = (cls != 2'b00) | (new_ent.word[16] & (new_ent.word[1:0] != 2'b11));
        new_ent.ryu   = (cls != 2'b00);
      end
      UNIT_SHF: begin
        new_ent.wflag = 1'b1;
        new_ent.rxu   = 1'b1;
        new_ent.ryu   = ~new_ent.word[16];
      end
      default: ;
    endcase
  end

  cmpt_iss_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .wdata_i (new_ent),
    .pop_i   (issue),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head = entry_t'(fifo_rdata);

  assign conflict = last_wv_q &
                    ((head.rxu & (head.word[RX_HI:RX_LO] == last_wa_q)) |
                     (head.ryu & (head.word[RY_HI:RY_LO] == last_wa_q)));
  assign can_go = ~fifo_empty & ~iss_hold;
  assign issue  = can_go & ~conflict;
  assign stall  = can_go & conflict;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + SONE;
  end

  // Output / issue stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpt_en_q    <= 1'b0;
      bt_26_q     <= 1'b0;
      bt_5t25_q   <= '0;
      enc_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      last_wv_q   <= 1'b0;
    end else begin
      cpt_en_q    <= issue;
      enc_err_q   <= ill_acc;
      stall_cnt_q <= stall_cnt_d;
      last_wv_q   <= issue & head.wflag;
      if (issue) begin
        bt_5t25_q <= head.word;
        bt_26_q   <= head.flt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) last_wa_q <= head.word[WA_HI:WA_LO];
  end

  assign cpt_en    = cpt_en_q;
  assign bt_26     = bt_26_q;
  assign bt_5t25   = bt_5t25_q;
  assign enc_err   = enc_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cmpt_inst_encdr.sv
// Scoreboard bench for cmpt_inst_encdr: directed requests with hand-computed words.
module tb_cmpt_inst_encdr;

  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [1:0]  req_unit = '0;
  logic        req_float = 1'b0;
  logic [6:0]  req_ctl = '0;
  logic [3:0]  req_wa = '0, req_ra0 = '0, req_ray = '0;
  logic [1:0]  req_msc = '0;
  logic        iss_hold = 1'b0;
  logic        cpt_en, bt_26, enc_err;
  logic [20:0] bt_5t25;
  logic [CNTW-1:0] stall_cnt;

  typedef struct packed {
    logic [20:0] word;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];
  int   iss_cyc[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  cmpt_inst_encdr #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_unit  (req_unit),
    .req_float (req_float),
    .req_ctl   (req_ctl),
    .req_wa    (req_wa),
    .req_ra0   (req_ra0),
    .req_ray   (req_ray),
    .req_msc   (req_msc),
    .iss_hold  (iss_hold),
    .cpt_en    (cpt_en),
    .bt_26     (bt_26),
    .bt_5t25   (bt_5t25),
    .enc_err   (enc_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (cpt_en) begin
        iss_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got word 0x%0h expected no issue", bt_5t25);
        end else begin
          e = exp_q.pop_front();
          chk("issue_word", 32'(bt_5t25), 32'(e.word));
          chk("issue_float", 32'(bt_26), 32'(e.flt));
        end
      end
    end
  endtask

  task automatic send(input logic [1:0] unit, input logic flt, input logic [6:0] ctl,
                      input logic [3:0] wa, input logic [3:0] ra0, input logic [3:0] ray,
                      input logic [1:0] msc, input logic expect_issue, input logic [20:0] ew);
    int t;
    exp_t e;
    req_unit = unit; req_float = flt; req_ctl = ctl;
    req_wa = wa; req_ra0 = ra0; req_ray = ray; req_msc = msc;
    req_vld = 1'b1;
    e.word = ew;
    e.flt  = flt;
    if (expect_issue) exp_q.push_back(e);
    t = 0;
    while (!req_rdy && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_rdy) chk("send_timeout_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    #12;
    chk("rst_cpt_en", 32'(cpt_en), 32'd0);
    chk("rst_bt_26", 32'(bt_26), 32'd0);
    chk("rst_word", 32'(bt_5t25), 32'd0);
    chk("rst_enc_err", 32'(enc_err), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_rdy", 32'(req_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic ALU, two-edge latency
    send(2'b00, 1'b0, 7'h00, 4'd3, 4'd1, 4'd2, 2'b00, 1'b1, 21'h000312);
    chk("lat_first_edge", 32'(cpt_en), 32'd0);
    @(posedge clk); #1;
    chk("lat_second_edge", 32'(cpt_en), 32'd1);
    chk("lat_word", 32'(bt_5t25), 32'h000312);
    drain();

    // Float ALU, SHF forced zeros, MUL class != 0 ignoring msc
    send(2'b00, 1'b1, 7'h45, 4'd1, 4'd2, 4'd3, 2'b00, 1'b1, 21'h045123);
    send(2'b10, 1'b0, 7'h7F, 4'd4, 4'd5, 4'd6, 2'b00, 1'b1, 21'h118456);
    send(2'b01, 1'b0, 7'h20, 4'd7, 4'd8, 4'd9, 2'b11, 1'b1, 21'h0A0789);
    drain();
    chk("no_hazard_stall", 32'(stall_cnt), 32'd0);

    // Rx read-after-write: one bubble
    iss_cyc.delete();
    send(2'b00, 1'b0, 7'h00, 4'd5, 4'd0, 4'd0, 2'b00, 1'b1, 21'h000500);
    send(2'b00, 1'b0, 7'h00, 4'd7, 4'd5, 4'd1, 2'b00, 1'b1, 21'h000751);
    drain();
    chk("rx_haz_issues", 32'(iss_cyc.size()), 32'd2);
    if (iss_cyc.size() == 2) chk("rx_haz_gap", 32'(iss_cyc[1] - iss_cyc[0]), 32'd2);
    chk("rx_haz_stall", 32'(stall_cnt), 32'd1);

    // Same pair reading R6: no bubble
    iss_cyc.delete();
    send(2'b00, 1'b0, 7'h00, 4'd5, 4'd0, 4'd0, 2'b00, 1'b1, 21'h000500);
    send(2'b00, 1'b0, 7'h00, 4'd7, 4'd6, 4'd6, 2'b00, 1'b1, 21'h000766);
    drain();
    if (iss_cyc.size() == 2) chk("nohaz_gap", 32'(iss_cyc[1] - iss_cyc[0]), 32'd1);
    else chk("nohaz_issues", 32'(iss_cyc.size()), 32'd2);
    chk("nohaz_stall", 32'(stall_cnt), 32'd1);

    // MUL class 0, Rx unused even though ra0 matches prior write
    iss_cyc.delete();
    send(2'b00, 1'b0, 7'h00, 4'd5, 4'd0, 4'd0, 2'b00, 1'b1, 21'h000500);
    send(2'b01, 1'b0, 7'h10, 4'd2, 4'd5, 4'hF, 2'b11, 1'b1, 21'h090253);
    drain();
    if (iss_cyc.size() == 2) chk("mul_gap", 32'(iss_cyc[1] - iss_cyc[0]), 32'd1);
    else chk("mul_issues", 32'(iss_cyc.size()), 32'd2);
    chk("mul_stall", 32'(stall_cnt), 32'd1);

    // Ry read-after-write: one bubble
    iss_cyc.delete();
    send(2'b00, 1'b0, 7'h00, 4'd5, 4'd0, 4'd0, 2'b00, 1'b1, 21'h000500);
    send(2'b00, 1'b0, 7'h00, 4'd7, 4'd0, 4'd5, 2'b00, 1'b1, 21'h000705);
    drain();
    if (iss_cyc.size() == 2) chk("ry_haz_gap", 32'(iss_cyc[1] - iss_cyc[0]), 32'd2);
    else chk("ry_haz_issues", 32'(iss_cyc.size()), 32'd2);
    chk("ry_haz_stall", 32'(stall_cnt), 32'd2);

    // Fill under hold, then release
    iss_cyc.delete();
    iss_hold = 1'b1;
    send(2'b00, 1'b0, 7'h00, 4'd8, 4'd0, 4'd1, 2'b00, 1'b1, 21'h000801);
    send(2'b00, 1'b0, 7'h00, 4'd9, 4'd0, 4'd1, 2'b00, 1'b1, 21'h000901);
    send(2'b00, 1'b0, 7'h00, 4'hA, 4'd0, 4'd1, 2'b00, 1'b1, 21'h000A01);
    chk("fill_rdy_3", 32'(req_rdy), 32'd1);
    send(2'b00, 1'b0, 7'h00, 4'hB, 4'd0, 4'd1, 2'b00, 1'b1, 21'h000B01);
    chk("fill_rdy_4", 32'(req_rdy), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("hold_no_issue", 32'(iss_cyc.size()), 32'd0);
    iss_hold = 1'b0;
    send(2'b00, 1'b0, 7'h00, 4'hC, 4'd0, 4'd1, 2'b00, 1'b1, 21'h000C01);
    drain();
    chk("fill_issues", 32'(iss_cyc.size()), 32'd5);
    chk("fill_stall", 32'(stall_cnt), 32'd2);

    // Illegal unit: error pulse, no FIFO slot used
    iss_hold = 1'b1;
    send(2'b00, 1'b0, 7'h00, 4'hD, 4'd0, 4'd1, 2'b00, 1'b1, 21'h000D01);
    send(2'b00, 1'b0, 7'h00, 4'hE, 4'd0, 4'd1, 2'b00, 1'b1, 21'h000E01);
    send(2'b00, 1'b0, 7'h00, 4'hF, 4'd0, 4'd1, 2'b00, 1'b1, 21'h000F01);
    send(2'b11, 1'b0, 7'h7F, 4'd1, 4'd1, 4'd1, 2'b00, 1'b0, 21'h0);
    chk("ill_err_pulse", 32'(enc_err), 32'd1);
    chk("ill_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
    chk("ill_err_clear", 32'(enc_err), 32'd0);
    send(2'b00, 1'b0, 7'h00, 4'd2, 4'd0, 4'd1, 2'b00, 1'b1, 21'h000201);
    chk("ill_count_full", 32'(req_rdy), 32'd0);
    iss_hold = 1'b0;
    drain();

    // Reset with queued entries
    iss_hold = 1'b1;
    send(2'b00, 1'b0, 7'h00, 4'd3, 4'd4, 4'd4, 2'b00, 1'b0, 21'h0);
    send(2'b00, 1'b0, 7'h00, 4'd3, 4'd4, 4'd4, 2'b00, 1'b0, 21'h0);
    send(2'b00, 1'b0, 7'h00, 4'd3, 4'd4, 4'd4, 2'b00, 1'b0, 21'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_cpt_en", 32'(cpt_en), 32'd0);
    chk("mid_rst_word", 32'(bt_5t25), 32'd0);
    chk("mid_rst_float", 32'(bt_26), 32'd0);
    chk("mid_rst_enc_err", 32'(enc_err), 32'd0);
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
    chk("mid_rst_rdy", 32'(req_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    iss_hold = 1'b0;
    iss_cyc.delete();
    repeat (6) begin @(posedge clk); #1; end
    chk("post_rst_idle", 32'(iss_cyc.size()), 32'd0);
    send(2'b00, 1'b0, 7'h00, 4'd3, 4'd1, 4'd2, 2'b00, 1'b1, 21'h000312);
    drain();
    chk("post_rst_issues", 32'(iss_cyc.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
